// File: rtl/led_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_pkg : shared mode/state encodings and width helper for the LED engine
// Revision: 1.0
// ---------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    MODE_CONVERGE   = 2'd0,
    MODE_DIVERGE    = 2'd1,
    MODE_BOUNCE     = 2'd2,
    MODE_FILL_DRAIN = 2'd3
  } mode_e;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_step_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_step_counter : modulo-period step counter with wrap pulse
// Revision: 1.0
// ---------------------------------------------------------------------------
module led_step_counter #(
  parameter int STEP_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              restart,
  input  logic [STEP_W-1:0] period,
  output logic [STEP_W-1:0] step,
  output logic              last,
  output logic              illegal,
  output logic              cycle_done
);

  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;
  logic              cycle_done_q;
  logic              cycle_done_d;

  assign illegal = (step_q >= period);
  assign last    = (step_q == (period - STEP_W'(1)));

  always_comb begin
    step_d       = step_q;
    cycle_done_d = 1'b0;
    // An out-of-range count is pulled back to zero immediately, tick or not
    if (restart || illegal) begin
      step_d = '0;
    end else if (advance) begin
      if (last) begin
        step_d       = '0;
        cycle_done_d = 1'b1;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q       <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      step_q       <= step_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign step       = step_q;
  assign cycle_done = cycle_done_q;

endmodule
`default_nettype wire

// File: rtl/led_pattern_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_pattern_engine : four-mode LED sequencer with pause and tick-aligned switch
// Revision: 1.0
// ---------------------------------------------------------------------------
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int LED_W      = 8,
  parameter int HOLD_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             pause,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] leds,
  output logic [1:0]       active_mode,
  output logic             cycle_done
);

  localparam int STEP_W = clog2(2 * LED_W + HOLD_TICKS);

  localparam logic [STEP_W-1:0] c_half          = STEP_W'(LED_W / 2);
  localparam logic [STEP_W-1:0] c_led_w         = STEP_W'(LED_W);
  localparam logic [STEP_W-1:0] c_led_last      = STEP_W'(LED_W - 1);
  localparam logic [STEP_W-1:0] c_bounce_top    = STEP_W'(2 * LED_W - 2);
  localparam logic [STEP_W-1:0] c_drain_top     = STEP_W'(2 * LED_W - 1);
  localparam logic [STEP_W-1:0] c_period_hold   = STEP_W'(LED_W / 2 + HOLD_TICKS);
  localparam logic [STEP_W-1:0] c_period_bounce = STEP_W'(2 * LED_W - 2);
  localparam logic [STEP_W-1:0] c_period_fill   = STEP_W'(2 * LED_W);
  localparam logic [LED_W-1:0]  c_one           = LED_W'(1);

  logic [LED_W-1:0]  leds_q;
  logic [LED_W-1:0]  leds_d;
  logic [1:0]        active_mode_q;
  logic [1:0]        active_mode_d;
  state_e            state_q;
  state_e            state_d;

  logic              w_accept;
  logic              w_mode_diff;
  logic              w_restart;
  logic              w_advance;
  logic [STEP_W-1:0] w_period;
  logic [STEP_W-1:0] w_step;
  logic [STEP_W-1:0] w_pos;
  logic              w_last;
  logic              w_illegal;

  assign w_accept    = tick & ~pause;
  // A pending switch is the live compare: it arms while mode differs and
  // cancels as soon as mode matches again, so the tick itself decides.
  assign w_mode_diff = (mode != active_mode_q);
  assign w_restart   = w_accept & w_mode_diff;
  assign w_advance   = w_accept & ~w_mode_diff;

  always_comb begin
    w_period = c_period_fill;
    case (active_mode_q)
      MODE_CONVERGE,
      MODE_DIVERGE:    w_period = c_period_hold;
      MODE_BOUNCE:     w_period = c_period_bounce;
      MODE_FILL_DRAIN: w_period = c_period_fill;
    endcase
  end

  led_step_counter #(
    .STEP_W (STEP_W)
  ) u_step_counter (
    .clk        (clk),
    .reset      (reset),
    .advance    (w_advance),
    .restart    (w_restart),
    .period     (w_period),
    .step       (w_step),
    .last       (w_last),
    .illegal    (w_illegal),
    .cycle_done (cycle_done)
  );

  // Bounce position folds the second half of the period back toward bit 0
  assign w_pos = (w_step < c_led_w) ? w_step : (c_bounce_top - w_step);

  always_comb begin
    leds_d        = leds_q;
    state_d       = state_q;
    active_mode_d = active_mode_q;
    if (w_restart) begin
      active_mode_d = mode;
      leds_d        = '0;
      state_d       = ST_RUN;
    end else if (w_illegal) begin
      leds_d  = '0;
      state_d = ST_RUN;
    end else if (w_advance) begin
      case (active_mode_q)
        MODE_CONVERGE,
        MODE_DIVERGE: begin
          if (state_q == ST_RUN) begin
            if (active_mode_q == MODE_CONVERGE) begin
              leds_d = leds_q | (c_one << w_step) | (c_one << (c_led_last - w_step));
            end else begin
              leds_d = leds_q | (c_one << (c_half - STEP_W'(1) - w_step))
                              | (c_one << (c_half + w_step));
            end
            if (w_step == (c_half - STEP_W'(1))) begin
              state_d = ST_HOLD;
            end
          end else begin
            leds_d = '0;
            if (w_last) begin
              state_d = ST_RUN;
            end
          end
        end
        MODE_BOUNCE: begin
          leds_d = c_one << w_pos;
        end
        MODE_FILL_DRAIN: begin
          if (w_step < c_led_w) begin
            leds_d = leds_q | (c_one << w_step);
          end else begin
            leds_d = leds_q & ~(c_one << (c_drain_top - w_step));
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q        <= '0;
      active_mode_q <= 2'd0;
      state_q       <= ST_RUN;
    end else begin
      leds_q        <= leds_d;
      active_mode_q <= active_mode_d;
      state_q       <= state_d;
    end
  end

  assign leds        = leds_q;
  assign active_mode = active_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_led_pattern_engine : directed self-checking bench for 8-LED and 12-LED builds
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_led_pattern_engine;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        tick  = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  mode  = 2'd0;

  logic [7:0]  leds;
  logic [1:0]  active_mode;
  logic        cycle_done;
  logic [11:0] leds_w;
  logic [1:0]  active_mode_w;
  logic        cycle_done_w;

  int checks = 0;
  int errors = 0;

  logic [7:0]  s_leds;
  logic        s_cd;
  logic [1:0]  s_am;
  logic [11:0] s_leds_w;
  logic        s_cd_w;

  always #5 clk = ~clk;

  led_pattern_engine #(.LED_W(8), .HOLD_TICKS(4)) dut (
    .clk(clk), .reset(reset), .tick(tick), .pause(pause), .mode(mode),
    .leds(leds), .active_mode(active_mode), .cycle_done(cycle_done)
  );

  led_pattern_engine #(.LED_W(12), .HOLD_TICKS(2)) dut_w (
    .clk(clk), .reset(reset), .tick(tick), .pause(pause), .mode(mode),
    .leds(leds_w), .active_mode(active_mode_w), .cycle_done(cycle_done_w)
  );

  // One tick with mode applied on the same cycle; outputs captured just after the edge
  task automatic pulse_tick(input logic [1:0] m);
    @(negedge clk);
    mode = m;
    tick = 1'b1;
    @(negedge clk);
    tick     = 1'b0;
    s_leds   = leds;
    s_cd     = cycle_done;
    s_am     = active_mode;
    s_leds_w = leds_w;
    s_cd_w   = cycle_done_w;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (leds !== 8'h00) begin errors++; $display("FAIL reset_leds: got %h expected 00", leds); end
    checks++;
    if (active_mode !== 2'd0) begin errors++; $display("FAIL reset_active_mode: got %0d expected 0", active_mode); end
    checks++;
    if (cycle_done !== 1'b0) begin errors++; $display("FAIL reset_cycle_done: got %b expected 0", cycle_done); end
    checks++;
    if (leds_w !== 12'h000) begin errors++; $display("FAIL reset_leds_w: got %h expected 000", leds_w); end
    reset = 1'b0;
  endtask

  task automatic test_converge();
    logic [7:0] exp_leds [9];
    exp_leds = '{8'h81, 8'hC3, 8'hE7, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81};
    for (int i = 0; i < 9; i++) begin
      pulse_tick(2'd0);
      checks++;
      if (s_leds !== exp_leds[i]) begin errors++; $display("FAIL converge_leds tick %0d: got %h expected %h", i + 1, s_leds, exp_leds[i]); end
      checks++;
      if (s_cd !== 1'(i == 7)) begin errors++; $display("FAIL converge_cycle_done tick %0d: got %b expected %b", i + 1, s_cd, 1'(i == 7)); end
    end
  endtask

  task automatic test_diverge();
    logic [7:0] exp_leds [8];
    exp_leds = '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_tick(2'd1);
    checks++;
    if (s_leds !== 8'h00 || s_am !== 2'd1 || s_cd !== 1'b0) begin
      errors++; $display("FAIL diverge_restart: got leds=%h mode=%0d done=%b expected 00/1/0", s_leds, s_am, s_cd);
    end
    for (int i = 0; i < 8; i++) begin
      pulse_tick(2'd1);
      checks++;
      if (s_leds !== exp_leds[i]) begin errors++; $display("FAIL diverge_leds tick %0d: got %h expected %h", i + 1, s_leds, exp_leds[i]); end
      checks++;
      if (s_cd !== 1'(i == 7)) begin errors++; $display("FAIL diverge_cycle_done tick %0d: got %b expected %b", i + 1, s_cd, 1'(i == 7)); end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] exp_leds [15];
    exp_leds = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    pulse_tick(2'd2);
    checks++;
    if (s_leds !== 8'h00 || s_am !== 2'd2 || s_cd !== 1'b0) begin
      errors++; $display("FAIL bounce_restart: got leds=%h mode=%0d done=%b expected 00/2/0", s_leds, s_am, s_cd);
    end
    for (int i = 0; i < 15; i++) begin
      pulse_tick(2'd2);
      checks++;
      if (s_leds !== exp_leds[i]) begin errors++; $display("FAIL bounce_leds tick %0d: got %h expected %h", i + 1, s_leds, exp_leds[i]); end
      checks++;
      if (s_cd !== 1'(i == 13)) begin errors++; $display("FAIL bounce_cycle_done tick %0d: got %b expected %b", i + 1, s_cd, 1'(i == 13)); end
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_leds [16];
    exp_leds = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    pulse_tick(2'd3);
    checks++;
    if (s_leds !== 8'h00 || s_am !== 2'd3 || s_cd !== 1'b0) begin
      errors++; $display("FAIL fill_restart: got leds=%h mode=%0d done=%b expected 00/3/0", s_leds, s_am, s_cd);
    end
    for (int i = 0; i < 16; i++) begin
      pulse_tick(2'd3);
      checks++;
      if (s_leds !== exp_leds[i]) begin errors++; $display("FAIL fill_leds tick %0d: got %h expected %h", i + 1, s_leds, exp_leds[i]); end
      checks++;
      if (s_cd !== 1'(i == 15)) begin errors++; $display("FAIL fill_cycle_done tick %0d: got %b expected %b", i + 1, s_cd, 1'(i == 15)); end
    end
  endtask

  task automatic test_pause_switch();
    pulse_tick(2'd0);
    pulse_tick(2'd0);
    pulse_tick(2'd0);
    checks++;
    if (s_leds !== 8'hC3 || s_am !== 2'd0) begin errors++; $display("FAIL pause_setup: got leds=%h mode=%0d expected C3/0", s_leds, s_am); end
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pulse_tick(2'd2);
      checks++;
      if (s_leds !== 8'hC3 || s_am !== 2'd0 || s_cd !== 1'b0) begin
        errors++; $display("FAIL pause_hold tick %0d: got leds=%h mode=%0d done=%b expected C3/0/0", i + 1, s_leds, s_am, s_cd);
      end
    end
    pause = 1'b0;
    pulse_tick(2'd2);
    checks++;
    if (s_leds !== 8'h00 || s_am !== 2'd2 || s_cd !== 1'b0) begin
      errors++; $display("FAIL pause_restart: got leds=%h mode=%0d done=%b expected 00/2/0", s_leds, s_am, s_cd);
    end
    pulse_tick(2'd2);
    checks++;
    if (s_leds !== 8'h01) begin errors++; $display("FAIL pause_first_step: got %h expected 01", s_leds); end
  endtask

  task automatic test_reset_mid();
    pulse_tick(2'd3);
    for (int i = 0; i < 6; i++) pulse_tick(2'd3);
    checks++;
    if (s_leds !== 8'h3F || s_am !== 2'd3) begin errors++; $display("FAIL midreset_setup: got leds=%h mode=%0d expected 3F/3", s_leds, s_am); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (leds !== 8'h00 || active_mode !== 2'd0) begin
      errors++; $display("FAIL midreset_async: got leds=%h mode=%0d expected 00/0", leds, active_mode);
    end
    @(negedge clk);
    reset = 1'b0;
    pulse_tick(2'd3);
    checks++;
    if (s_leds !== 8'h00 || s_am !== 2'd3 || s_cd !== 1'b0) begin
      errors++; $display("FAIL midreset_restart: got leds=%h mode=%0d done=%b expected 00/3/0", s_leds, s_am, s_cd);
    end
    pulse_tick(2'd3);
    checks++;
    if (s_leds !== 8'h01) begin errors++; $display("FAIL midreset_first_step: got %h expected 01", s_leds); end
  endtask

  task automatic test_wide();
    logic [11:0] exp_leds [9];
    exp_leds = '{12'h801, 12'hC03, 12'hE07, 12'hF0F, 12'hF9F, 12'hFFF, 12'h000, 12'h000, 12'h801};
    @(negedge clk);
    mode  = 2'd0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pulse_tick(2'd0);
      checks++;
      if (s_leds_w !== exp_leds[i]) begin errors++; $display("FAIL wide_leds tick %0d: got %h expected %h", i + 1, s_leds_w, exp_leds[i]); end
      checks++;
      if (s_cd_w !== 1'(i == 7)) begin errors++; $display("FAIL wide_cycle_done tick %0d: got %b expected %b", i + 1, s_cd_w, 1'(i == 7)); end
    end
  endtask

  task automatic test_back_to_back();
    // Short-lived mode change that reverts before any tick: no restart
    @(negedge clk);
    mode = 2'd1;
    repeat (3) @(negedge clk);
    mode = 2'd0;
    pulse_tick(2'd0);
    checks++;
    if (s_leds !== 8'hC3 || s_am !== 2'd0) begin errors++; $display("FAIL cancel_switch: got leds=%h mode=%0d expected C3/0", s_leds, s_am); end
    pulse_tick(2'd2);
    checks++;
    if (s_leds !== 8'h00 || s_am !== 2'd2 || s_cd !== 1'b0) begin
      errors++; $display("FAIL simultaneous_restart: got leds=%h mode=%0d done=%b expected 00/2/0", s_leds, s_am, s_cd);
    end
    pulse_tick(2'd2);
    checks++;
    if (s_leds !== 8'h01) begin errors++; $display("FAIL simultaneous_first_step: got %h expected 01", s_leds); end
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    checks++;
    if (leds !== 8'h02) begin errors++; $display("FAIL b2b_first: got %h expected 02", leds); end
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (leds !== 8'h04) begin errors++; $display("FAIL b2b_second: got %h expected 04", leds); end
  endtask

  initial begin
    test_reset();
    test_converge();
    test_diverge();
    test_bounce();
    test_fill_drain();
    test_pause_switch();
    test_reset_mid();
    test_wide();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
